// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, immediate formats and the
// control bundle handed from decode to execute.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] funct3;
        logic       reg_wr;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op: ALU_ADD, alu_src_imm: 1'b0, alu_src_pc: 1'b0, mem_rd: 1'b0,
        mem_wr: 1'b0, funct3: 3'b000, reg_wr: 1'b0, branch: 1'b0, jump: 1'b0,
        illegal: 1'b0
    };

    // alt selects SUB/SRA; callers must only raise it where the encoding allows it
    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] i);
        logic signed [31:0] imm;
        case (t)
            IMM_I:   imm = {{21{i[31]}}, i[30:20]};
            IMM_S:   imm = {{21{i[31]}}, i[30:25], i[11:7]};
            IMM_B:   imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            IMM_J:   imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/d_regfile.sv
// Architectural register file: two combinational read ports, one write port, x0 reads as zero.
module d_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [XLEN-1:0] rd_data_a,
    output logic [XLEN-1:0] rd_data_b
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, register read and the ID/EX register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data into the captured operands.
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            f_valid_i,
    input  logic [31:0]     f_pc_i,
    input  logic [31:0]     f_instr_i,
    output logic            d_ready_o,
    input  logic            br_en_i,
    input  logic            e_ready_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            d_valid_o,
    output logic [31:0]     d_pc_o,
    output logic [XLEN-1:0] d_rs1_data_o,
    output logic [XLEN-1:0] d_rs2_data_o,
    output logic [31:0]     d_imm_o,
    output logic [4:0]      d_rs1_o,
    output logic [4:0]      d_rs2_o,
    output logic [4:0]      d_rd_o,
    output ctrl_t           d_ctrl_o
);

    ctrl_t           ctrl_p0;
    imm_type_e       imm_t_p0;
    logic            legal_p0;
    logic            uses_rs1_p0, uses_rs2_p0;
    logic [2:0]      f3_p0;
    logic [6:0]      f7_p0;
    logic [4:0]      rs1_p0, rs2_p0, rd_p0;
    logic [XLEN-1:0] rf_rs1_p0, rf_rs2_p0, op1_p0, op2_p0;
    logic            hazard, accept;

    logic            vld_p1;
    logic [31:0]     pc_p1, imm_p1;
    logic [XLEN-1:0] rs1_data_p1, rs2_data_p1;
    logic [4:0]      rs1_p1, rs2_p1, rd_p1;
    ctrl_t           ctrl_p1;

    assign f3_p0  = f_instr_i[14:12];
    assign f7_p0  = f_instr_i[31:25];
    assign rs1_p0 = f_instr_i[19:15];
    assign rs2_p0 = f_instr_i[24:20];
    assign rd_p0  = f_instr_i[11:7];

    // ---- p0: decode of the instruction presented by fetch
    always_comb begin
        ctrl_p0        = CTRL_NOP;
        ctrl_p0.funct3 = f3_p0;
        imm_t_p0       = IMM_NONE;
        legal_p0       = 1'b1;
        uses_rs1_p0    = 1'b0;
        uses_rs2_p0    = 1'b0;
        case (f_instr_i[6:0])
            OPC_LUI: begin
                ctrl_p0.alu_op      = ALU_PASSB;
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.reg_wr      = 1'b1;
                imm_t_p0            = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.alu_src_pc  = 1'b1;
                ctrl_p0.reg_wr      = 1'b1;
                imm_t_p0            = IMM_U;
            end
            OPC_JAL: begin
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.alu_src_pc  = 1'b1;
                ctrl_p0.reg_wr      = 1'b1;
                ctrl_p0.jump        = 1'b1;
                imm_t_p0            = IMM_J;
            end
            OPC_JALR: begin
                legal_p0            = (f3_p0 == 3'b000);
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.reg_wr      = 1'b1;
                ctrl_p0.jump        = 1'b1;
                imm_t_p0            = IMM_I;
                uses_rs1_p0         = 1'b1;
            end
            OPC_BRANCH: begin
                legal_p0       = (f3_p0[2:1] != 2'b01);
                ctrl_p0.branch = 1'b1;
                ctrl_p0.alu_op = !f3_p0[2] ? ALU_SUB : (f3_p0[1] ? ALU_SLTU : ALU_SLT);
                imm_t_p0       = IMM_B;
                uses_rs1_p0    = 1'b1;
                uses_rs2_p0    = 1'b1;
            end
            OPC_LOAD: begin
                legal_p0            = (f3_p0 != 3'b011) && (f3_p0[2:1] != 2'b11);
                ctrl_p0.mem_rd      = 1'b1;
                ctrl_p0.reg_wr      = 1'b1;
                ctrl_p0.alu_src_imm = 1'b1;
                imm_t_p0            = IMM_I;
                uses_rs1_p0         = 1'b1;
            end
            OPC_STORE: begin
                legal_p0            = !f3_p0[2] && (f3_p0[1:0] != 2'b11);
                ctrl_p0.mem_wr      = 1'b1;
                ctrl_p0.alu_src_imm = 1'b1;
                imm_t_p0            = IMM_S;
                uses_rs1_p0         = 1'b1;
                uses_rs2_p0         = 1'b1;
            end
            OPC_OPIMM: begin
                // Shift-immediates reuse imm[11:5] as funct7; other OP-IMMs treat it as immediate
                if (f3_p0 == 3'b001)      legal_p0 = (f7_p0 == 7'b0000000);
                else if (f3_p0 == 3'b101) legal_p0 = (f7_p0 == 7'b0000000) || (f7_p0 == 7'b0100000);
                ctrl_p0.alu_op      = alu_from_funct(f3_p0, (f3_p0 == 3'b101) && f_instr_i[30]);
                ctrl_p0.alu_src_imm = 1'b1;
                ctrl_p0.reg_wr      = 1'b1;
                imm_t_p0            = IMM_I;
                uses_rs1_p0         = 1'b1;
            end
            OPC_OP: begin
                legal_p0 = (f7_p0 == 7'b0000000) ||
                           ((f7_p0 == 7'b0100000) && ((f3_p0 == 3'b000) || (f3_p0 == 3'b101)));
                ctrl_p0.alu_op = alu_from_funct(f3_p0, f_instr_i[30]);
                ctrl_p0.reg_wr = 1'b1;
                uses_rs1_p0    = 1'b1;
                uses_rs2_p0    = 1'b1;
            end
            default: legal_p0 = 1'b0;
        endcase
        if (!legal_p0) begin
            ctrl_p0         = CTRL_NOP;
            ctrl_p0.illegal = 1'b1;
            imm_t_p0        = IMM_NONE;
        end
    end

    d_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wb_en_i),
        .wr_addr   (wb_rd_i),
        .wr_data   (wb_data_i),
        .rd_addr_a (rs1_p0),
        .rd_addr_b (rs2_p0),
        .rd_data_a (rf_rs1_p0),
        .rd_data_b (rf_rs2_p0)
    );

`ifdef DECODE_WB_BYPASS_EN
    assign op1_p0 = (wb_en_i && wb_rd_i != 5'd0 && wb_rd_i == rs1_p0) ? wb_data_i : rf_rs1_p0;
    assign op2_p0 = (wb_en_i && wb_rd_i != 5'd0 && wb_rd_i == rs2_p0) ? wb_data_i : rf_rs2_p0;
`else
    assign op1_p0 = rf_rs1_p0;
    assign op2_p0 = rf_rs2_p0;
`endif

    // Load-use: the loaded value is not available until after execute, so hold the consumer
    assign hazard = vld_p1 && ctrl_p1.mem_rd && (rd_p1 != 5'd0) &&
                    ((uses_rs1_p0 && rs1_p0 == rd_p1) || (uses_rs2_p0 && rs2_p0 == rd_p1));
    assign d_ready_o = (!vld_p1 || e_ready_i) && !hazard;
    assign accept    = f_valid_i && d_ready_o && !br_en_i;

    // ---- p1: ID/EX register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            imm_p1      <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            ctrl_p1     <= CTRL_NOP;
        end else if (br_en_i) begin
            vld_p1 <= 1'b0;
        end else if (hazard && e_ready_i) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1      <= 1'b1;
            pc_p1       <= f_pc_i;
            imm_p1      <= gen_imm(imm_t_p0, f_instr_i);
            rs1_data_p1 <= op1_p0;
            rs2_data_p1 <= op2_p0;
            rs1_p1      <= rs1_p0;
            rs2_p1      <= rs2_p0;
            rd_p1       <= rd_p0;
            ctrl_p1     <= ctrl_p0;
        end else if (e_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign d_valid_o    = vld_p1;
    assign d_pc_o       = pc_p1;
    assign d_imm_o      = imm_p1;
    assign d_rs1_data_o = rs1_data_p1;
    assign d_rs2_data_o = rs2_data_p1;
    assign d_rs1_o      = rs1_p1;
    assign d_rs2_o      = rs2_p1;
    assign d_rd_o       = rd_p1;
    assign d_ctrl_o     = ctrl_p1;

endmodule
